serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  controller can accept a request.
REQ-006 SHALL have port i_a  input  W  operand A.
REQ-007 SHALL have port i_b  input  W  operand B.
REQ-008 SHALL have port i_carry  input  1  carry-in to nibble 0.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  consumer accepts result.
REQ-011 SHALL have port o_sum  output  W  result.
REQ-012 SHALL have port o_carry  output  1  carry-out of the top nibble.
REQ-013 SHALL have port o_ovf  output  1  signed overflow: carry into top bit XOR carry out of top bit.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: o_ready=1; i_valid=1 at an edge latches i_a, i_b and i_carry, clears the nibble index and moves to BUSY.
REQ-016 BUSY: o_ready=0; each edge adds operand nibble[idx] plus the carry register, writes result nibble[idx], stores carry-out, increments idx.
REQ-017 After the edge processing nibble NIBBLES-1, SHALL enter DONE; o_valid is first high NIBBLES edges after the accepting edge.
REQ-018 DONE: o_valid=1, o_ready=0; o_sum, o_carry and o_ovf SHALL stay stable until i_ready=1 at an edge, then move to IDLE.
REQ-019 Back-to-back: o_ready stays 0 in DONE, so a new request is accepted one cycle after the result handshake at the earliest (one bubble, by design).
REQ-020 i_valid while o_ready=0 SHALL be ignored (no queuing); operand inputs SHALL only be sampled at the accepting edge.
REQ-021 o_sum, o_carry and o_ovf SHALL be undefined-free: they hold the last result, or zero after reset, while not in DONE.
REQ-022 Arithmetic SHALL be modulo 2^W; o_carry is bit W of A+B+cin.

Reset
REQ-023 i_rst_n low SHALL asynchronously force IDLE, o_ready=1, o_valid=0, o_sum=0, o_carry=0, o_ovf=0, idx=0, carry register=0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation; no o_valid for the aborted request.

Configuration
REQ-025 Macro SERIAL_ADD_CTRL_SUB_EN defined: SHALL add port i_sub (input, 1, latched with the operands); when i_sub=1 the result is A + ~B + 1, with i_carry ignored.
REQ-026 Macro absent: SHALL have no i_sub port and perform addition only.

Structure
REQ-027 SHALL place the FSM state enum and the nibble-width constant (4) in shared package serial_add_pkg.
REQ-028 SHALL instantiate exactly one fourbitadder as its datapath sub-module, driven from the nibble multiplexers; there SHALL be no other adder.

Verification
REQ-029 0x1234 + 0x4321, cin=0 -> o_sum=0x5555, o_carry=0, o_ovf=0; o_valid 4 edges after accept.
REQ-030 0xFFFF + 0x0001, cin=0 -> o_sum=0x0000, o_carry=1; 0x7FFF + 0x0001 -> o_sum=0x8000, o_ovf=1.
REQ-031 0x00FF + 0x0000, cin=1 -> o_sum=0x0100; i_valid pulsed during BUSY with other operands -> ignored, result unchanged.
REQ-032 i_ready held 0 for 3 cycles in DONE -> o_valid and o_sum stable; i_ready=1 -> IDLE next cycle, o_ready=1.
REQ-033 Reset asserted 2 edges after accept -> immediate IDLE, outputs zero, no o_valid; a new request then completes normally.
REQ-034 With SERIAL_ADD_CTRL_SUB_EN: 0x0005 - 0x0007 -> o_sum=0xFFFE, o_carry=0; 0x0007 - 0x0005 -> o_sum=0x0002, o_carry=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial add controller.
package serial_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/fourbitadder.sv
// One-nibble ripple adder; also exposes the carry into bit 3 for overflow detection.
module fourbitadder
  import serial_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             c3,
  output logic             cout
);

  logic [NIB_W-1:0] low;
  logic [1:0]       top;

  // Split at bit 3 so the carry into the MSB is visible to the controller.
  always_comb begin
    low  = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};
    top  = {1'b0, a[NIB_W-1]} + {1'b0, b[NIB_W-1]} + {1'b0, low[NIB_W-1]};
    sum  = {top[0], low[NIB_W-2:0]};
    c3   = low[NIB_W-1];
    cout = top[1];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder with valid/ready handshakes; one nibble per clock.
// Optional subtract mode (extra i_sub port) enabled by macro SERIAL_ADD_CTRL_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NIB_W*NIBBLES-1:0] i_a,
  input  logic [NIB_W*NIBBLES-1:0] i_b,
  input  logic                   i_carry,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic                   i_sub,
`endif
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NIB_W*NIBBLES-1:0] o_sum,
  output logic                   o_carry,
  output logic                   o_ovf
);

  localparam int W    = NIB_W * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     work;
  logic             carry_reg;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_c3;
  logic             nib_cout;
  logic [W-1:0]     next_work;

  always_comb begin
    a_nib     = a_reg[idx*NIB_W +: NIB_W];
    b_nib     = b_reg[idx*NIB_W +: NIB_W];
    next_work = work;
    next_work[idx*NIB_W +: NIB_W] = nib_sum;
  end

  fourbitadder u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .c3   (nib_c3),
    .cout (nib_cout)
  );

  // Outputs only update on the last nibble, so they hold the previous result while busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_sum     <= '0;
      o_carry   <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg   <= i_a;
`ifdef SERIAL_ADD_CTRL_SUB_EN
            b_reg     <= i_sub ? ~i_b : i_b;
            carry_reg <= i_sub ? 1'b1 : i_carry;
`else
            b_reg     <= i_b;
            carry_reg <= i_carry;
`endif
            idx     <= '0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          work      <= next_work;
          carry_reg <= nib_cout;
          idx       <= idx + 1'b1;
          if (idx == LAST) begin
            o_sum   <= next_work;
            o_carry <= nib_cout;
            o_ovf   <= nib_c3 ^ nib_cout;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
